// File: rtl/upsample1d_nearest.sv
// Streaming 1-D nearest-neighbour upsampler: each input beat of P lanes is
// replayed as SCALE_FACTOR output beats. Optional stall counter: UPSAMPLE1D_NEAREST_PERF_CNT_EN.
module upsample1d_nearest #(
    parameter int DATA_IN_0_PRECISION_0        = 8,
    parameter int DATA_IN_0_PRECISION_1        = 3,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_0  = 8,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_1  = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_0  = 4,
    parameter int SCALE_FACTOR                 = 2,
    parameter int DATA_OUT_0_PRECISION_0       = 8,
    parameter int DATA_OUT_0_PRECISION_1       = 3,
    parameter int DATA_OUT_0_TENSOR_SIZE_DIM_0 = 16,
    parameter int DATA_OUT_0_PARALLELISM_DIM_0 = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0 [DATA_IN_0_PARALLELISM_DIM_0],
    input  logic                              data_in_0_valid,
    output logic                              data_in_0_ready,
    output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0 [DATA_OUT_0_PARALLELISM_DIM_0],
    output logic                              data_out_0_valid,
    input  logic                              data_out_0_ready
`ifdef UPSAMPLE1D_NEAREST_PERF_CNT_EN
    ,
    output logic [31:0]                       stall_cnt
`endif
);

    localparam int P     = DATA_IN_0_PARALLELISM_DIM_0;
    localparam int S     = SCALE_FACTOR;
    localparam int W     = DATA_IN_0_PRECISION_0;
    localparam int CNT_W = (S > 1) ? $clog2(S) : 1;
    localparam logic [CNT_W-1:0] LAST_REP = CNT_W'(S - 1);

    if (DATA_OUT_0_PRECISION_0 != DATA_IN_0_PRECISION_0) begin : g_chk_prec0
        $error("upsample1d_nearest: output precision_0 must equal input precision_0");
    end
    if (DATA_OUT_0_PRECISION_1 != DATA_IN_0_PRECISION_1) begin : g_chk_prec1
        $error("upsample1d_nearest: output precision_1 must equal input precision_1");
    end
    if (DATA_OUT_0_TENSOR_SIZE_DIM_0 != DATA_IN_0_TENSOR_SIZE_DIM_0 * SCALE_FACTOR) begin : g_chk_size
        $error("upsample1d_nearest: output dim 0 must be input dim 0 times SCALE_FACTOR");
    end
    if (DATA_OUT_0_PARALLELISM_DIM_0 != DATA_IN_0_PARALLELISM_DIM_0) begin : g_chk_par
        $error("upsample1d_nearest: output parallelism must equal input parallelism");
    end
    if (SCALE_FACTOR < 1) begin : g_chk_scale
        $error("upsample1d_nearest: SCALE_FACTOR must be at least 1");
    end
    if (DATA_IN_0_TENSOR_SIZE_DIM_1 < 1) begin : g_chk_rows
        $error("upsample1d_nearest: at least one row required");
    end

    logic [W-1:0]     data_buf [P];
    logic             buf_valid;
    logic [CNT_W-1:0] rep_cnt;
    logic             last_rep;
    logic             out_hs;
    logic             in_hs;

    assign last_rep         = (rep_cnt == LAST_REP);
    assign out_hs           = buf_valid && data_out_0_ready;
    assign data_in_0_ready  = !buf_valid || (data_out_0_ready && last_rep);
    assign in_hs            = data_in_0_valid && data_in_0_ready;
    assign data_out_0_valid = buf_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 1'b0;
            rep_cnt   <= '0;
            for (int i = 0; i < P; i++) data_buf[i] <= '0;
        end else begin
            if (out_hs) begin
                rep_cnt <= last_rep ? '0 : rep_cnt + CNT_W'(1);
            end
            if (in_hs) begin
                buf_valid <= 1'b1;
                data_buf  <= data_in_0;
            end else if (out_hs && last_rep) begin
                buf_valid <= 1'b0;
            end
        end
    end

    // Each lane picks its source element from a constant table indexed by rep_cnt.
    for (genvar l = 0; l < P; l++) begin : g_lane
        logic [W-1:0] cand [S];
        for (genvar r = 0; r < S; r++) begin : g_rep
            assign cand[r] = data_buf[(r * P + l) / S];
        end
        assign data_out_0[l] = cand[rep_cnt];
    end

`ifdef UPSAMPLE1D_NEAREST_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (buf_valid && !data_out_0_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/upsample1d_nearest.md
Name: upsample1d_nearest

Overview:
Streaming 1-D nearest-neighbour upsampler; the expanding counterpart of the 1-D average-pooling blocks in the pooling_layers library.
- Takes beats of DATA_IN_0_PARALLELISM_DIM_0 elements and repeats each element SCALE_FACTOR times along dim 0.
- Emits SCALE_FACTOR output beats per input beat, using a one-beat buffer and a repeat counter under valid/ready handshakes.
- Sits between a pooling/conv stage and a decoder-style consumer.

Parameters:
DATA_IN_0_PRECISION_0, 8, total bit width of each element
DATA_IN_0_PRECISION_1, 3, fractional bits (pass-through only, no arithmetic)
DATA_IN_0_TENSOR_SIZE_DIM_0, 8, input elements per row
DATA_IN_0_TENSOR_SIZE_DIM_1, 1, rows
DATA_IN_0_PARALLELISM_DIM_0, 4, lanes per beat (P)
SCALE_FACTOR, 2, repeat factor S, >=1
DATA_OUT_0_PRECISION_0, 8, must equal DATA_IN_0_PRECISION_0
DATA_OUT_0_PRECISION_1, 3, must equal DATA_IN_0_PRECISION_1
DATA_OUT_0_TENSOR_SIZE_DIM_0, 16, must equal DATA_IN_0_TENSOR_SIZE_DIM_0*SCALE_FACTOR
DATA_OUT_0_PARALLELISM_DIM_0, 4, must equal DATA_IN_0_PARALLELISM_DIM_0

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
data_in_0  input  [DATA_IN_0_PRECISION_0-1:0] x P (unpacked array)  input lanes; lane 0 = lowest tensor index
data_in_0_valid  input  1  input beat valid
data_in_0_ready  output  1  input beat accepted when valid&&ready
data_out_0  output  [DATA_OUT_0_PRECISION_0-1:0] x P (unpacked array)  output lanes
data_out_0_valid  output  1  output beat valid
data_out_0_ready  input  1  downstream ready

Behaviour:
- Interface: one clock domain. Reset is synchronous and active-high on rst, sampled on the rising edge of clk.
- Elaboration checks: initial-block asserts for every "must equal" parameter relation and for SCALE_FACTOR>=1; violation calls $error.
- State:
  - buf[P]: data register.
  - buf_valid: 1 bit.
  - rep_cnt: 0..S-1, width $clog2(S) with a minimum of 1.
- Output mapping (combinational from state):
  - data_out_0[l] = buf[(rep_cnt*P + l) / S], for l in 0..P-1.
  - data_out_0_valid = buf_valid.
- Ready: data_in_0_ready = !buf_valid || (data_out_0_ready && rep_cnt==S-1). This gives zero-bubble back-to-back operation.
- Per clock (not in reset):
  - Output handshake, rep_cnt<S-1: rep_cnt++.
  - Output handshake, rep_cnt==S-1: rep_cnt<=0; buf_valid<=data_in_0_valid.
  - Input handshake: buf<=data_in_0 (covers both the empty case and same-cycle replacement on the last repeat).
  - No output handshake: buf, rep_cnt and data_out_0 are held stable while valid is high (AXI-stream rule).
- Latency: first output beat is valid the cycle after the input handshake.
- Throughput: one output beat per cycle with continuous ready. Input sustains 1 beat per S cycles.
- S==1: pure one-stage register slice with full throughput. The mux degenerates to identity.
- Data transfer is bit-exact; no rounding or saturation.
- Row boundaries need no special handling: each input beat expands independently. DIM_1 is used for the elaboration checks only.
- Reset values:
  - buf_valid=0, rep_cnt=0, buf=all zeros.
  - Hence data_out_0_valid=0, data_out_0=0, data_in_0_ready=1 in the cycle after reset.
- Reset mid-operation: any in-flight beat and its remaining repeats are discarded. No partial output follows reset.
- Input valid while full and not on the last repeat: ready=0, input held upstream, no loss.

Optional Feature:
UPSAMPLE1D_NEAREST_PERF_CNT_EN
- Defined: adds output port stall_cnt (output, 32 bits). It counts cycles with data_out_0_valid && !data_out_0_ready, saturates at 0xFFFFFFFF, and resets to 0 on rst.
- Undefined: no port, no counter logic. Datapath behaviour is identical in both builds.

Test Plan:
- P=1,S=2, out_ready=1; inputs 3,5 back-to-back -> outputs 3,3,5,5 on consecutive cycles; in_ready pattern 1,0,1,0.
- P=4,S=2; input [1,2,3,4] (lane0..3) -> beats [1,1,2,2] then [3,3,4,4].
- P=4,S=2,out_ready toggling 1,0,1,0; inputs [1,2,3,4],[5,6,7,8] -> same beat sequence, held stable during stalls, no drop or duplicate. With PERF_CNT_EN: stall_cnt equals the number of 0-ready valid cycles.
- S=1,P=2; stream 100 random beats, out_ready=1 -> identical stream delayed 1 cycle; no bubbles.
- P=1,S=4; input 7, assert rst after 2 outputs -> next cycle valid=0, in_ready=1. Then input 9 -> 9,9,9,9 with no leftover 7s.
- P=1,S=3; data_in_0_valid held high with value -2 (0xF0) while full -> 3 outputs of 0xF0, in_ready high only on the last-repeat cycle.
